timer0_reg_ctrl: RTL and testbench
==================================

Name: timer0_reg_ctrl

Overview:
Register-file and interrupt controller that owns the Timer/Counter0 control state and feeds `timer_unit`. It sits between the CPU I/O bus and `timer_unit`, and drives `mem_tccr0a`, `mem_tccr0b`, `mem_tcnt0`, `mem_ocr0a` and `mem_ocr0b`. It arbitrates CPU writes against timer counter updates, double-buffers OCR0A/OCR0B in PWM modes, maintains the TIFR0 flags and TIMSK0 masks, and runs the interrupt request/acknowledge handshake to the CPU.

Parameters:
DATA_WIDTH, 8, register and bus data width
ADDR_WIDTH, 6, I/O address width
ADDR_TIFR0, 6'h15, TIFR0 address
ADDR_TCCR0A, 6'h24, TCCR0A address
ADDR_TCCR0B, 6'h25, TCCR0B address
ADDR_TCNT0, 6'h26, TCNT0 address
ADDR_OCR0A, 6'h27, OCR0A address
ADDR_OCR0B, 6'h28, OCR0B address
ADDR_TIMSK0, 6'h2E, TIMSK0 address

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
bus_addr  in  ADDR_WIDTH  I/O address
bus_wr_en  in  1  write strobe
bus_rd_en  in  1  read strobe
bus_wdata  in  DATA_WIDTH  write data
bus_rdata  out  DATA_WIDTH  read data, registered
tmr_tcnt0  in  DATA_WIDTH  next counter value from `timer_unit`
tmr_tick  in  1  one-clk pulse: `timer_unit` advanced, tmr_tcnt0 valid
mem_tccr0a, mem_tccr0b, mem_tcnt0, mem_ocr0a, mem_ocr0b  out  DATA_WIDTH each  architectural registers to `timer_unit` (OCR = active copy)
irq_req  out  1  interrupt request
irq_vec  out  2  1=COMPA, 2=COMPB, 3=OVF, 0=none
irq_ack  in  1  CPU accepts the request

Behaviour:
- Clock is clk. Reset is reset: synchronous and active-high. Every register and output resets to 0 on the first clk edge where reset=1, including mid-handshake. irq_req drops immediately and the FSM returns to IDLE.
- Writes take effect at the edge where bus_wr_en=1. Unmapped addresses are ignored on write and read 0.
- Reads: bus_rdata is valid 1 cycle after bus_rd_en. It returns the register value (OCR returns the CPU-visible buffer value) and holds until the next read.
- TIFR0 bit map: bit0 TOV0, bit1 OCF0A, bit2 OCF0B; bits 7:3 read 0. TIMSK0 uses the same positions (TOIE0, OCIE0A, OCIE0B).
- TCNT0 arbitration: if tmr_tick coincides with a CPU write to TCNT0, the CPU value wins and the tick is dropped. Otherwise, on tmr_tick, mem_tcnt0 <= tmr_tcnt0.
- Compare block: a CPU TCNT0 write suppresses OCF0A/OCF0B setting on the next tmr_tick only.
- Flags on tmr_tick:
  - TOV0 sets when tmr_tcnt0 == 0 and mem_tcnt0 != 0.
  - OCF0A sets when tmr_tcnt0 == active OCR0A.
  - OCF0B sets when tmr_tcnt0 == active OCR0B.
- Flag clear: writing 1 to a TIFR0 bit clears it. If a set and a clear land in the same cycle, the set wins.
- OCR buffering: PWM means WGM0 = {TCCR0B[3], TCCR0A[1:0]} is 3 or 7.
  - In PWM, CPU writes go to the buffer; active <= buffer on the tmr_tick where tmr_tcnt0 == 0.
  - Otherwise, writes update buffer and active in the same cycle.
  - Switching out of PWM copies buffer to active on the next cycle.
- IRQ FSM:
  - IDLE: pending = TIFR0 & TIMSK0. If nonzero, latch irq_vec by priority COMPA > COMPB > OVF, assert irq_req, go to REQ.
  - REQ: hold irq_req and irq_vec stable.
    - irq_ack=1: clear the flag of the latched vector (a same-cycle set is lost), drop irq_req, go to GAP.
    - Latched flag or mask cleared without ack: drop irq_req, irq_vec=0, go to IDLE.
  - GAP: one cycle, irq_req=0, irq_vec=0, then IDLE.
  - irq_ack outside REQ is ignored.

Optional Feature:
Macro: TIMER_FORCE_COMPARE_EN.
- Enabled:
  - Adds outputs foc0a and foc0b (1 bit each).
  - Writing TCCR0B with bit7=1 (FOC0A) or bit6=1 (FOC0B) pulses the matching output for exactly 1 cycle, only when WGM0 is non-PWM.
  - Flags are not set, and bits 7:6 always read 0.
- Disabled: the ports are absent, TCCR0B bits 7:6 are not stored, and they read 0.

Test Plan:
- Reset: write TCCR0A=8'h83, assert reset 1 cycle -> all mem_* = 0, bus_rdata = 0, irq_req = 0.
- Collision: CPU writes TCNT0=8'h40 while tmr_tick=1 with tmr_tcnt0=8'h11 -> mem_tcnt0 = 8'h40. Next tick with tmr_tcnt0 = OCR0A = 8'h41 -> OCF0A stays 0.
- Buffering: WGM0=3, OCR0A active 8'h80, CPU writes 8'h20 -> mem_ocr0a = 8'h80 until a tick with tmr_tcnt0 = 0, then 8'h20. With WGM0=0 the update is immediate.
- Priority/handshake: TIMSK0 = 3'b111, OVF and COMPB flags set -> irq_vec = 2. After ack: OCF0B = 0, 1 GAP cycle, then irq_vec = 3.
- Withdraw: in REQ with vector 1, write TIFR0 = 8'h02 -> irq_req = 0 next cycle, FSM in IDLE.
- Set/clear race: TOV0 set tick plus TIFR0 = 8'h01 write in the same cycle -> TOV0 = 1. With TIMER_FORCE_COMPARE_EN and WGM0=2, write TCCR0B = 8'h81 -> foc0a high for exactly 1 cycle.

Source files
------------

// File: rtl/timer0_reg_ctrl.sv
// timer0_reg_ctrl: Timer/Counter0 register file, OCR double-buffering, TIFR0/TIMSK0 flags and IRQ handshake.
// Optional macro TIMER_FORCE_COMPARE_EN adds foc0a/foc0b force-compare strobes.
module timer0_reg_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter logic [ADDR_WIDTH-1:0] ADDR_TIFR0  = 6'h15,
    parameter logic [ADDR_WIDTH-1:0] ADDR_TCCR0A = 6'h24,
    parameter logic [ADDR_WIDTH-1:0] ADDR_TCCR0B = 6'h25,
    parameter logic [ADDR_WIDTH-1:0] ADDR_TCNT0  = 6'h26,
    parameter logic [ADDR_WIDTH-1:0] ADDR_OCR0A  = 6'h27,
    parameter logic [ADDR_WIDTH-1:0] ADDR_OCR0B  = 6'h28,
    parameter logic [ADDR_WIDTH-1:0] ADDR_TIMSK0 = 6'h2E
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_wr_en,
    input  logic                  bus_rd_en,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic [DATA_WIDTH-1:0] tmr_tcnt0,
    input  logic                  tmr_tick,
    output logic [DATA_WIDTH-1:0] mem_tccr0a,
    output logic [DATA_WIDTH-1:0] mem_tccr0b,
    output logic [DATA_WIDTH-1:0] mem_tcnt0,
    output logic [DATA_WIDTH-1:0] mem_ocr0a,
    output logic [DATA_WIDTH-1:0] mem_ocr0b,
    output logic                  irq_req,
    output logic [1:0]            irq_vec,
`ifdef TIMER_FORCE_COMPARE_EN
    output logic                  foc0a,
    output logic                  foc0b,
`endif
    input  logic                  irq_ack
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t                state_q;
    logic [DATA_WIDTH-1:0] tccr0a_q, tcnt0_q, ocra_buf_q, ocra_q, ocra_d, ocrb_buf_q, ocrb_q, ocrb_d, rdata_q, rd_mux;
    logic [DATA_WIDTH-3:0] tccr0b_q;
    logic [2:0]            tifr_q, tifr_d, timsk_q, timsk_d, set_v, clr_v, ack_clr, vec_bit, pend;
    logic                  blk_q, pwm_prev_q, pwm, tick_ok, load_act, unload, irq_req_q;
    logic [1:0]            irq_vec_q;
    logic                  wr_tifr, wr_tccr0a, wr_tccr0b, wr_tcnt0, wr_ocra, wr_ocrb, wr_timsk;
    assign wr_tifr   = bus_wr_en && bus_addr == ADDR_TIFR0;
    assign wr_tccr0a = bus_wr_en && bus_addr == ADDR_TCCR0A;
    assign wr_tccr0b = bus_wr_en && bus_addr == ADDR_TCCR0B;
    assign wr_tcnt0  = bus_wr_en && bus_addr == ADDR_TCNT0;
    assign wr_ocra   = bus_wr_en && bus_addr == ADDR_OCR0A;
    assign wr_ocrb   = bus_wr_en && bus_addr == ADDR_OCR0B;
    assign wr_timsk  = bus_wr_en && bus_addr == ADDR_TIMSK0;
    // WGM0 of 3 or 7 is PWM: only the low two bits (from TCCR0A) decide it
    assign pwm      = tccr0a_q[1:0] == 2'b11;
    assign tick_ok  = tmr_tick && !wr_tcnt0;
    assign load_act = pwm && tick_ok && tmr_tcnt0 == '0;
    assign unload   = pwm_prev_q && !pwm;
    assign ocra_d   = wr_ocra && !pwm ? bus_wdata : (load_act || unload) ? ocra_buf_q : ocra_q;
    assign ocrb_d   = wr_ocrb && !pwm ? bus_wdata : (load_act || unload) ? ocrb_buf_q : ocrb_q;
    assign set_v    = tick_ok ? {!blk_q && tmr_tcnt0 == ocrb_q, !blk_q && tmr_tcnt0 == ocra_q,
                                 tmr_tcnt0 == '0 && tcnt0_q != '0} : 3'b000;
    assign clr_v    = wr_tifr ? bus_wdata[2:0] : 3'b000;
    assign vec_bit  = irq_vec_q == 2'd1 ? 3'b010 : irq_vec_q == 2'd2 ? 3'b100 : irq_vec_q == 2'd3 ? 3'b001 : 3'b000;
    assign ack_clr  = state_q == REQ && irq_ack ? vec_bit : 3'b000;
    assign tifr_d   = ((tifr_q & ~clr_v) | set_v) & ~ack_clr;
    assign timsk_d  = wr_timsk ? bus_wdata[2:0] : timsk_q;
    assign pend     = tifr_q & timsk_q;
    assign rd_mux   = bus_addr == ADDR_TIFR0  ? {{(DATA_WIDTH-3){1'b0}}, tifr_q} :
                      bus_addr == ADDR_TCCR0A ? tccr0a_q :
                      bus_addr == ADDR_TCCR0B ? {2'b00, tccr0b_q} :
                      bus_addr == ADDR_TCNT0  ? tcnt0_q :
                      bus_addr == ADDR_OCR0A  ? ocra_buf_q :
                      bus_addr == ADDR_OCR0B  ? ocrb_buf_q :
                      bus_addr == ADDR_TIMSK0 ? {{(DATA_WIDTH-3){1'b0}}, timsk_q} : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            tccr0a_q   <= '0;
            tccr0b_q   <= '0;
            tcnt0_q    <= '0;
            ocra_buf_q <= '0;
            ocrb_buf_q <= '0;
            ocra_q     <= '0;
            ocrb_q     <= '0;
            tifr_q     <= '0;
            timsk_q    <= '0;
            blk_q      <= 1'b0;
            pwm_prev_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (wr_tccr0a) tccr0a_q <= bus_wdata;
            if (wr_tccr0b) tccr0b_q <= bus_wdata[DATA_WIDTH-3:0];
            if (wr_tcnt0 || tmr_tick) tcnt0_q <= wr_tcnt0 ? bus_wdata : tmr_tcnt0;
            if (wr_ocra) ocra_buf_q <= bus_wdata;
            if (wr_ocrb) ocrb_buf_q <= bus_wdata;
            ocra_q     <= ocra_d;
            ocrb_q     <= ocrb_d;
            tifr_q     <= tifr_d;
            timsk_q    <= timsk_d;
            blk_q      <= wr_tcnt0 || (blk_q && !tmr_tick);
            pwm_prev_q <= pwm;
            if (bus_rd_en) rdata_q <= rd_mux;
        end
    end
    // Withdraw looks at next-state flags/masks so a clearing write drops irq_req at its own edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            irq_vec_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: if (pend != 3'b000) begin
                    irq_req_q <= 1'b1;
                    irq_vec_q <= pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
                    state_q   <= REQ;
                end
                REQ: if (irq_ack) begin
                    irq_req_q <= 1'b0;
                    irq_vec_q <= 2'd0;
                    state_q   <= GAP;
                end else if ((vec_bit & tifr_d & timsk_d) == 3'b000) begin
                    irq_req_q <= 1'b0;
                    irq_vec_q <= 2'd0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef TIMER_FORCE_COMPARE_EN
    logic foc0a_q, foc0b_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            foc0a_q <= 1'b0;
            foc0b_q <= 1'b0;
        end else begin
            foc0a_q <= wr_tccr0b && bus_wdata[7] && !pwm;
            foc0b_q <= wr_tccr0b && bus_wdata[6] && !pwm;
        end
    end
    assign foc0a = foc0a_q;
    assign foc0b = foc0b_q;
`endif
    assign bus_rdata  = rdata_q;
    assign mem_tccr0a = tccr0a_q;
    assign mem_tccr0b = {2'b00, tccr0b_q};
    assign mem_tcnt0  = tcnt0_q;
    assign mem_ocr0a  = ocra_q;
    assign mem_ocr0b  = ocrb_q;
    assign irq_req    = irq_req_q;
    assign irq_vec    = irq_vec_q;
endmodule

// File: tb/tb_timer0_reg_ctrl.sv
// tb_timer0_reg_ctrl: directed and randomized checks of timer0_reg_ctrl against an address-indexed register model.
module tb_timer0_reg_ctrl;
    localparam logic [5:0] A_TIFR = 6'h15, A_TA = 6'h24, A_TB = 6'h25, A_TCNT = 6'h26,
                           A_OA = 6'h27, A_OB = 6'h28, A_MSK = 6'h2E;
    logic       clk = 1'b0, reset = 1'b0;
    logic [5:0] bus_addr = '0;
    logic       bus_wr_en = 1'b0, bus_rd_en = 1'b0, tmr_tick = 1'b0, irq_ack = 1'b0;
    logic [7:0] bus_wdata = '0, tmr_tcnt0 = '0;
    logic [7:0] bus_rdata, mem_tccr0a, mem_tccr0b, mem_tcnt0, mem_ocr0a, mem_ocr0b;
    logic       irq_req;
    logic [1:0] irq_vec;
`ifdef TIMER_FORCE_COMPARE_EN
    logic       foc0a, foc0b;
`endif
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    timer0_reg_ctrl dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .tmr_tcnt0(tmr_tcnt0), .tmr_tick(tmr_tick),
        .mem_tccr0a(mem_tccr0a), .mem_tccr0b(mem_tccr0b), .mem_tcnt0(mem_tcnt0),
        .mem_ocr0a(mem_ocr0a), .mem_ocr0b(mem_ocr0b), .irq_req(irq_req), .irq_vec(irq_vec),
`ifdef TIMER_FORCE_COMPARE_EN
        .foc0a(foc0a), .foc0b(foc0b),
`endif
        .irq_ack(irq_ack)
    );
    // Model: CPU-visible registers live at their bus address; active OCRs and IRQ phase kept beside them
    logic [7:0] m [64];
    logic [7:0] m_act_a, m_act_b, m_rdata;
    logic       m_blk, m_was_pwm, m_req, m_foca, m_focb;
    logic [1:0] m_vec;
    int         m_phase;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_step();
        logic [7:0] tc_old, ba, bb, fo, fn, mk_old, wgm, pend;
        logic       pwm, wr_tcnt, ok, ack;
        logic [2:0] set, clr;
        if (reset) begin
            foreach (m[i]) m[i] = 8'h00;
            {m_act_a, m_act_b, m_rdata} = '0;
            {m_blk, m_was_pwm, m_req, m_foca, m_focb} = '0;
            m_vec = 2'd0;
            m_phase = 0;
            return;
        end
        wgm = {5'd0, m[A_TB][3], m[A_TA][1:0]};
        pwm = wgm == 8'd3 || wgm == 8'd7;
        tc_old = m[A_TCNT]; ba = m[A_OA]; bb = m[A_OB]; fo = m[A_TIFR]; mk_old = m[A_MSK];
        wr_tcnt = bus_wr_en && bus_addr == A_TCNT;
        ok = tmr_tick && !wr_tcnt;
        ack = m_phase == 1 && irq_ack;
        if (bus_rd_en) m_rdata = m[bus_addr];
        set = '0;
        if (ok) begin
            set[0] = tmr_tcnt0 == 8'd0 && tc_old != 8'd0;
            set[1] = !m_blk && tmr_tcnt0 == m_act_a;
            set[2] = !m_blk && tmr_tcnt0 == m_act_b;
        end
        clr = (bus_wr_en && bus_addr == A_TIFR) ? bus_wdata[2:0] : 3'b000;
        if (bus_wr_en) begin
            if (bus_addr == A_TA || bus_addr == A_TCNT || bus_addr == A_OA || bus_addr == A_OB) m[bus_addr] = bus_wdata;
            if (bus_addr == A_TB) m[bus_addr] = bus_wdata & 8'h3F;
            if (bus_addr == A_MSK) m[bus_addr] = bus_wdata & 8'h07;
        end
        if (ok) m[A_TCNT] = tmr_tcnt0;
        m_blk = wr_tcnt ? 1'b1 : ok ? 1'b0 : m_blk;
        fn = (fo & ~{5'd0, clr}) | {5'd0, set};
        if (ack) fn[int'(m_vec) % 3] = 1'b0;
        m[A_TIFR] = fn;
        if (!pwm) begin
            m_act_a = (bus_wr_en && bus_addr == A_OA) ? bus_wdata : m_was_pwm ? ba : m_act_a;
            m_act_b = (bus_wr_en && bus_addr == A_OB) ? bus_wdata : m_was_pwm ? bb : m_act_b;
        end else if (ok && tmr_tcnt0 == 8'd0) begin
            m_act_a = ba;
            m_act_b = bb;
        end
        m_was_pwm = pwm;
        m_foca = bus_wr_en && bus_addr == A_TB && bus_wdata[7] && !pwm;
        m_focb = bus_wr_en && bus_addr == A_TB && bus_wdata[6] && !pwm;
        pend = fo & mk_old;
        if (m_phase == 0) begin
            if (pend != 8'd0) begin
                m_vec = pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
                m_req = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (irq_ack) begin
                m_req = 1'b0; m_vec = 2'd0; m_phase = 2;
            end else if (!(fn[int'(m_vec) % 3] && m[A_MSK][int'(m_vec) % 3])) begin
                m_req = 1'b0; m_vec = 2'd0; m_phase = 0;
            end
        end else m_phase = 0;
    endtask
    task automatic check_all();
        check("tccr0a", mem_tccr0a, m[A_TA]);
        check("tccr0b", mem_tccr0b, m[A_TB]);
        check("tcnt0", mem_tcnt0, m[A_TCNT]);
        check("ocr0a", mem_ocr0a, m_act_a);
        check("ocr0b", mem_ocr0b, m_act_b);
        check("rdata", bus_rdata, m_rdata);
        check("irq_req", {7'd0, irq_req}, {7'd0, m_req});
        check("irq_vec", {6'd0, irq_vec}, {6'd0, m_vec});
`ifdef TIMER_FORCE_COMPARE_EN
        check("foc0a", {7'd0, foc0a}, {7'd0, m_foca});
        check("foc0b", {7'd0, foc0b}, {7'd0, m_focb});
`endif
    endtask
    task automatic cyc(input logic rst, input logic wr, input logic rd, input logic [5:0] a, input logic [7:0] d,
                       input logic tk, input logic [7:0] tc, input logic ak);
        reset = rst; bus_wr_en = wr; bus_rd_en = rd; bus_addr = a; bus_wdata = d;
        tmr_tick = tk; tmr_tcnt0 = tc; irq_ack = ak;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
        {reset, bus_wr_en, bus_rd_en, tmr_tick, irq_ack} = '0;
    endtask
    task automatic wr(input logic [5:0] a, input logic [7:0] d); cyc(0, 1, 0, a, d, 0, 8'd0, 0); endtask
    task automatic rd(input logic [5:0] a); cyc(0, 0, 1, a, 8'd0, 0, 8'd0, 0); endtask
    task automatic tick(input logic [7:0] tc); cyc(0, 0, 0, 6'd0, 8'd0, 1, tc, 0); endtask
    task automatic idle(); cyc(0, 0, 0, 6'd0, 8'd0, 0, 8'd0, 0); endtask
    task automatic ack(); cyc(0, 0, 0, 6'd0, 8'd0, 0, 8'd0, 1); endtask
    initial begin
        logic [5:0] addrs [9];
        addrs = '{A_TIFR, A_TA, A_TB, A_TCNT, A_OA, A_OB, A_MSK, 6'h3F, 6'h00};
        @(negedge clk);
        cyc(1, 0, 0, 6'd0, 8'd0, 0, 8'd0, 0);
        // Reset clears a written register and the read port
        wr(A_TA, 8'h83);
        rd(A_TA);
        check("pre_rst_rdata", bus_rdata, 8'h83);
        cyc(1, 0, 0, 6'd0, 8'd0, 0, 8'd0, 0);
        check("rst_tccr0a", mem_tccr0a, 8'h00);
        check("rst_rdata", bus_rdata, 8'h00);
        check("rst_irq", {7'd0, irq_req}, 8'h00);
        // CPU write wins over a coinciding tick, next compare is blocked
        wr(A_OA, 8'h41);
        cyc(0, 1, 0, A_TCNT, 8'h40, 1, 8'h11, 0);
        check("collide_tcnt", mem_tcnt0, 8'h40);
        tick(8'h41);
        rd(A_TIFR);
        check("cmp_block", bus_rdata, 8'h00);
        // PWM buffering
        wr(A_OA, 8'h80);
        wr(A_TA, 8'h03);
        wr(A_OA, 8'h20);
        check("buf_hold", mem_ocr0a, 8'h80);
        rd(A_OA);
        check("buf_read", bus_rdata, 8'h20);
        tick(8'h05);
        check("buf_hold2", mem_ocr0a, 8'h80);
        tick(8'h00);
        check("buf_load", mem_ocr0a, 8'h20);
        wr(A_TA, 8'h00);
        wr(A_OA, 8'h33);
        check("nopwm_imm", mem_ocr0a, 8'h33);
        // Priority and handshake
        wr(A_TIFR, 8'h07);
        wr(A_OB, 8'h50);
        tick(8'h07);
        tick(8'h00);
        tick(8'h50);
        wr(A_MSK, 8'h07);
        idle();
        check("prio_vec", {6'd0, irq_vec}, 8'd2);
        ack();
        check("ack_drop", {7'd0, irq_req}, 8'd0);
        rd(A_TIFR);
        check("ack_clr", bus_rdata, 8'h01);
        idle();
        check("next_vec", {6'd0, irq_vec}, 8'd3);
        ack();
        idle();
        // Withdraw by clearing the latched flag
        tick(8'h33);
        idle();
        check("wd_vec", {6'd0, irq_vec}, 8'd1);
        wr(A_TIFR, 8'h02);
        check("wd_req", {7'd0, irq_req}, 8'd0);
        idle();
        check("wd_idle", {7'd0, irq_req}, 8'd0);
        // Set beats clear in the same cycle
        wr(A_MSK, 8'h00);
        tick(8'h09);
        cyc(0, 1, 0, A_TIFR, 8'h01, 1, 8'h00, 0);
        rd(A_TIFR);
        check("set_wins", bus_rdata, 8'h01);
        wr(A_TIFR, 8'h07);
        // Force-compare bits never stored
        wr(A_TA, 8'h02);
        wr(A_TB, 8'h81);
`ifdef TIMER_FORCE_COMPARE_EN
        check("foc_pulse", {7'd0, foc0a}, 8'd1);
`endif
        rd(A_TB);
        check("tccr0b_rd", bus_rdata, 8'h01);
`ifdef TIMER_FORCE_COMPARE_EN
        check("foc_end", {7'd0, foc0a}, 8'd0);
`endif
        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] a;
            logic [7:0] d, tc;
            a = addrs[$urandom_range(0, 8)];
            d = $urandom_range(0, 255);
            if (a == A_TA && $urandom_range(0, 1) == 1) d[1:0] = 2'b11;
            tc = $urandom_range(0, 3) == 0 ? 8'd0 : $urandom_range(0, 2) == 0 ? m_act_a :
                 $urandom_range(0, 1) == 0 ? m_act_b : 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, a, d,
                $urandom_range(0, 1) == 1, tc, $urandom_range(0, 9) < 4);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
